// File: rtl/patch_addr_gen_if.sv
// Sample-address stream from patch_addr_gen to its consumer.
// master drives the beat (valid, address, band mask, flags); slave drives ready.
interface patch_addr_gen_if #(
    parameter int ADDR_DW  = 16,
    parameter int NUM_BAND = 4
);
    logic                addr_valid;
    logic                addr_ready;
    logic [ADDR_DW-1:0]  addr_out;
    logic [NUM_BAND-1:0] band_mask;
    logic                pix_oob;
    logic                last_kp;
    logic                last_all;

    modport master (
        output addr_valid, addr_out, band_mask, pix_oob, last_kp, last_all,
        input  addr_ready
    );

    modport slave (
        input  addr_valid, addr_out, band_mask, pix_oob, last_kp, last_all,
        output addr_ready
    );
endinterface

// File: rtl/patch_addr_gen.sv
// patch_addr_gen: for each stored keypoint, fetches its centre address and
// emits one address beat per pixel of a disc of radius RADIUS around it,
// tagged with concentric band membership.
// Optional feature: define BORDER_CLIP_EN to flag (pix_oob) and zero out
// beats whose pixel falls outside the IMG_W x IMG_H image instead of wrapping.
module patch_addr_gen #(
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int RADIUS   = 8,
    parameter int NUM_BAND = 4,
    parameter int ADDR_DW  = 16,
    parameter int KP_AW    = 9,
    parameter int WAIT_CYC = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [KP_AW-1:0]   kp_cnt,
    output logic [KP_AW-1:0]   kp_rd_addr,
    input  logic [ADDR_DW-1:0] kp_data,
    patch_addr_gen_if.master   addr_bus,
    output logic               busy,
    output logic               done
);
    localparam int WLOG = $clog2(IMG_W);
    localparam int CW   = $clog2(RADIUS + 1) + 1;
    localparam int SQW  = $clog2(2 * RADIUS * RADIUS + 1);
    localparam int WCW  = $clog2(WAIT_CYC + 1);

    localparam logic signed [CW-1:0] R_POS = CW'(RADIUS);
    localparam logic signed [CW-1:0] R_NEG = CW'(-RADIUS);

    if ((1 << WLOG) != IMG_W) begin : g_bad_img_w
        $error("patch_addr_gen: IMG_W must be a power of two");
    end
    if (IMG_H < 1) begin : g_bad_img_h
        $error("patch_addr_gen: IMG_H must be at least 1");
    end
    if (WAIT_CYC < 1) begin : g_bad_wait
        $error("patch_addr_gen: WAIT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SCAN, S_DONE} state_t;

    state_t                 state;
    logic [KP_AW-1:0]       idx;
    logic [KP_AW-1:0]       cnt;
    logic [WCW-1:0]         wcnt;
    logic [ADDR_DW-1:0]     centre;
    logic signed [CW-1:0]   dy;
    logic signed [CW-1:0]   dx;

    logic [CW-1:0]          adx, ady;
    logic [SQW-1:0]         ax, ay, d2;
    logic                   in_disc;
    logic [NUM_BAND-1:0]    band;
    int unsigned            rb;
    logic [ADDR_DW-1:0]     dy_ext, dx_ext, addr;
    logic                   at_last;
    logic                   last_idx;
    logic                   oob;
`ifdef BORDER_CLIP_EN
    int                     xi, yi;
`endif

    // Geometry of the current scan position: distance, bands, address, clip.
    always_comb begin
        rb       = 0;
        adx      = dx[CW-1] ? CW'(-dx) : dx;
        ady      = dy[CW-1] ? CW'(-dy) : dy;
        ax       = SQW'(adx);
        ay       = SQW'(ady);
        d2       = ax * ax + ay * ay;
        in_disc  = (d2 <= SQW'(RADIUS * RADIUS));
        band     = '0;
        for (int unsigned b = 0; b < NUM_BAND; b++) begin
            rb      = (RADIUS * (b + 1)) / NUM_BAND;
            band[b] = (32'(d2) <= rb * rb);
        end
        dy_ext   = ADDR_DW'(dy);
        dx_ext   = ADDR_DW'(dx);
        addr     = centre + (dy_ext << WLOG) + dx_ext;
        at_last  = (dy == R_POS) && (dx == '0);
        last_idx = (idx == cnt - KP_AW'(1));
`ifdef BORDER_CLIP_EN
        xi  = int'({1'b0, centre[WLOG-1:0]}) + int'(dx);
        yi  = int'(centre >> WLOG) + int'(dy);
        oob = (xi < 0) || (xi >= IMG_W) || (yi < 0) || (yi >= IMG_H);
`else
        oob = 1'b0;
`endif
    end

    // Control FSM with registered stream, memory-index and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= S_IDLE;
            idx                 <= '0;
            cnt                 <= '0;
            wcnt                <= '0;
            centre              <= '0;
            dy                  <= R_NEG;
            dx                  <= R_NEG;
            kp_rd_addr          <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
            addr_bus.addr_valid <= 1'b0;
            addr_bus.addr_out   <= '0;
            addr_bus.band_mask  <= '0;
            addr_bus.pix_oob    <= 1'b0;
            addr_bus.last_kp    <= 1'b0;
            addr_bus.last_all   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        cnt        <= kp_cnt;
                        idx        <= '0;
                        kp_rd_addr <= '0;
                        wcnt       <= '0;
                        busy       <= 1'b1;
                        if (kp_cnt == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (wcnt == WCW'(WAIT_CYC - 1)) begin
                        centre <= kp_data;
                        dy     <= R_NEG;
                        dx     <= R_NEG;
                        state  <= S_SCAN;
                    end else begin
                        wcnt <= wcnt + WCW'(1);
                    end
                end
                S_SCAN: begin
                    if (addr_bus.addr_valid && !addr_bus.addr_ready) begin
                        state <= S_SCAN;
                    end else if (addr_bus.addr_valid && addr_bus.last_kp) begin
                        // (+R,0) is the final in-disc point; later raster positions are never visited.
                        addr_bus.addr_valid <= 1'b0;
                        addr_bus.last_kp    <= 1'b0;
                        addr_bus.last_all   <= 1'b0;
                        if (last_idx) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            idx        <= idx + KP_AW'(1);
                            kp_rd_addr <= idx + KP_AW'(1);
                            wcnt       <= '0;
                            state      <= S_FETCH;
                        end
                    end else begin
                        if (in_disc) begin
                            addr_bus.addr_valid <= 1'b1;
                            addr_bus.addr_out   <= oob ? '0 : addr;
                            addr_bus.band_mask  <= oob ? '0 : band;
                            addr_bus.pix_oob    <= oob;
                            addr_bus.last_kp    <= at_last;
                            addr_bus.last_all   <= at_last && last_idx;
                        end else begin
                            addr_bus.addr_valid <= 1'b0;
                            addr_bus.last_kp    <= 1'b0;
                            addr_bus.last_all   <= 1'b0;
                        end
                        if (dx == R_POS) begin
                            dx <= R_NEG;
                            dy <= dy + CW'(1);
                        end else begin
                            dx <= dx + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_patch_addr_gen.sv
// Directed bench for patch_addr_gen: a RADIUS=2 instance for sequencing,
// stall, wrap/clip and reset cases, and a RADIUS=8 instance for band masks.
module tb_patch_addr_gen;
    logic       clk = 1'b0;
    logic       rst, start2, start8, ready;
    logic [8:0] kp_cnt;
    logic [8:0] rd2, rd8;
    logic [15:0] kpd2, kpd8;
    logic       busy2, done2, busy8, done8;
    logic [15:0] kp_mem [0:511];

    always #5 clk = ~clk;

    patch_addr_gen_if #(.ADDR_DW(16), .NUM_BAND(4)) bus2 ();
    patch_addr_gen_if #(.ADDR_DW(16), .NUM_BAND(4)) bus8 ();

    assign bus2.addr_ready = ready;
    assign bus8.addr_ready = ready;
    assign kpd2 = kp_mem[rd2];
    assign kpd8 = kp_mem[rd8];

    patch_addr_gen #(.IMG_W(256), .IMG_H(256), .RADIUS(2), .NUM_BAND(4),
                     .ADDR_DW(16), .KP_AW(9), .WAIT_CYC(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .kp_cnt(kp_cnt),
        .kp_rd_addr(rd2), .kp_data(kpd2), .addr_bus(bus2.master),
        .busy(busy2), .done(done2)
    );

    patch_addr_gen #(.IMG_W(256), .IMG_H(256), .RADIUS(8), .NUM_BAND(4),
                     .ADDR_DW(16), .KP_AW(9), .WAIT_CYC(2)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .kp_cnt(kp_cnt),
        .kp_rd_addr(rd8), .kp_data(kpd8), .addr_bus(bus8.master),
        .busy(busy8), .done(done8)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    int q2_addr[$], q2_mask[$], q2_oob[$], q2_lk[$], q2_la[$], q2_cyc[$];
    int q8_addr[$], q8_mask[$], q8_lk[$];
    int done2_n = 0, done2_cyc = 0, busy2_n = 0, busy2_rise = 0, done8_n = 0;
    logic busy2_d = 1'b0;

    // Beat offsets/masks for RADIUS=2 in raster order (thresholds 0,1,1,4).
    int exp_off [13] = '{-512, -257, -256, -255, -2, -1, 0, 1, 2, 255, 256, 257, 512};
    int exp_msk [13] = '{8, 8, 14, 8, 8, 14, 15, 14, 8, 8, 14, 8, 8};

    always @(posedge clk) cyc <= cyc + 1;

    // Record completed beats and status events from the RADIUS=2 instance.
    always @(negedge clk) begin
        busy2_d <= busy2;
        if (busy2 && !busy2_d) busy2_rise <= cyc;
        if (busy2) busy2_n <= busy2_n + 1;
        if (done2) begin
            done2_n   <= done2_n + 1;
            done2_cyc <= cyc;
        end
        if (bus2.addr_valid && bus2.addr_ready) begin
            q2_addr.push_back(int'(bus2.addr_out));
            q2_mask.push_back(int'(bus2.band_mask));
            q2_oob.push_back(int'(bus2.pix_oob));
            q2_lk.push_back(int'(bus2.last_kp));
            q2_la.push_back(int'(bus2.last_all));
            q2_cyc.push_back(cyc);
        end
    end

    // Record completed beats from the RADIUS=8 instance.
    always @(negedge clk) begin
        if (done8) done8_n <= done8_n + 1;
        if (bus8.addr_valid && bus8.addr_ready) begin
            q8_addr.push_back(int'(bus8.addr_out));
            q8_mask.push_back(int'(bus8.band_mask));
            q8_lk.push_back(int'(bus8.last_kp));
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_start2();
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
    endtask

    task automatic wait_done2(input string tag, input int budget);
        int base;
        int k;
        base = done2_n;
        k = 0;
        while (done2_n == base && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check(tag, int'(done2_n != base), 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, busy2, 0);
        check({tag, "_done"}, done2, 0);
        check({tag, "_rd"}, rd2, 0);
        check({tag, "_valid"}, bus2.addr_valid, 0);
        check({tag, "_addr"}, bus2.addr_out, 0);
        check({tag, "_mask"}, bus2.band_mask, 0);
        check({tag, "_flags"}, {bus2.pix_oob, bus2.last_kp, bus2.last_all}, 0);
    endtask

    task automatic check_seq2(input string tag, input int b, input int c);
        int n, nlk, noob;
        n = q2_addr.size() - b;
        nlk = 0;
        noob = 0;
        check({tag, "_beats"}, n, 13);
        for (int i = 0; i < 13 && i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), q2_addr[b+i], (c + exp_off[i]) & 16'hFFFF);
            check($sformatf("%s_mask%0d", tag, i), q2_mask[b+i], exp_msk[i]);
            nlk  += q2_lk[b+i];
            noob += q2_oob[b+i];
        end
        check({tag, "_nlast"}, nlk, 1);
        check({tag, "_noob"}, noob, 0);
        if (n > 0) begin
            check({tag, "_last_kp"}, q2_lk[q2_addr.size()-1], 1);
            check({tag, "_last_all"}, q2_la[q2_addr.size()-1], 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b, d0, bn, k, stalls, n, nlk, nla, noob, nbad_clip;
        int m0, m3, m8, c8;

        foreach (kp_mem[i]) kp_mem[i] = 16'h0;
        rst = 1'b1; start2 = 1'b0; start8 = 1'b0; ready = 1'b1; kp_cnt = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("RST");
        check("RST_busy8", busy8, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Single keypoint at (10,10), consumer always ready.
        kp_mem[0] = 16'd2570; kp_cnt = 9'd1;
        b = q2_addr.size();
        pulse_start2();
        check("A_busy", busy2, 1);
        check("A_rd", rd2, 0);
        wait_done2("A_done", 200);
        check_seq2("A", b, 2570);
        if (q2_addr.size() > b) begin
            check("A_first_lat", q2_cyc[b] - busy2_rise, 5);
            check("A_done_lat", done2_cyc - q2_cyc[q2_addr.size()-1], 1);
        end
        check("A_busy_end", busy2, 0);

        // Empty keypoint list.
        kp_cnt = 9'd0;
        b = q2_addr.size(); bn = busy2_n; d0 = done2_n;
        pulse_start2();
        wait_done2("B_done", 10);
        repeat (4) @(posedge clk);
        #1;
        check("B_beats", q2_addr.size() - b, 0);
        check("B_busy_cycles", busy2_n - bn, 1);
        check("B_done_pulses", done2_n - d0, 1);
        check("B_done_lat", done2_cyc - busy2_rise, 0);

        // Back-pressure on beat 5 for three cycles.
        kp_mem[0] = 16'd2570; kp_cnt = 9'd1;
        b = q2_addr.size(); d0 = done2_n; stalls = 0; k = 0;
        pulse_start2();
        while (done2_n == d0 && k < 300) begin
            @(posedge clk); #1;
            k++;
            if (bus2.addr_valid && (q2_addr.size() - b) == 4 && stalls < 3) begin
                ready = 1'b0;
                stalls++;
                @(negedge clk);
                check("C_hold_addr", bus2.addr_out, 2568);
                check("C_hold_mask", bus2.band_mask, 8);
                check("C_hold_valid", bus2.addr_valid, 1);
                check("C_hold_flags", {bus2.pix_oob, bus2.last_kp, bus2.last_all}, 0);
            end else begin
                ready = 1'b1;
            end
        end
        ready = 1'b1;
        check("C_done", int'(done2_n != d0), 1);
        check("C_stalls", stalls, 3);
        check_seq2("C", b, 2570);

        // Keypoint at the image origin: wrap or clip.
        kp_mem[0] = 16'd0; kp_cnt = 9'd1;
        b = q2_addr.size();
        pulse_start2();
        wait_done2("D_done", 200);
        n = q2_addr.size() - b;
        noob = 0; nbad_clip = 0;
        for (int i = 0; i < n; i++) begin
            noob += q2_oob[b+i];
            if (q2_oob[b+i] == 1 && (q2_addr[b+i] != 0 || q2_mask[b+i] != 0)) nbad_clip++;
        end
        check("D_beats", n, 13);
`ifdef BORDER_CLIP_EN
        check("D_noob", noob, 7);
        check("D_clip_zero", nbad_clip, 0);
        if (n > 6) check("D_centre", q2_addr[b+6], 0);
`else
        check("D_noob", noob, 0);
        if (n > 0) check("D_first", q2_addr[b], 65024);
`endif

        // RADIUS=8 band membership.
        c8 = 32896;
        kp_mem[0] = 16'(c8); kp_cnt = 9'd1;
        b = q8_addr.size(); d0 = done8_n;
        @(posedge clk); #1 start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        k = 0;
        while (done8_n == d0 && k < 700) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("E_done", int'(done8_n != d0), 1);
        m0 = -1; m3 = -1; m8 = -1; nlk = 0;
        for (int i = b; i < q8_addr.size(); i++) begin
            if (q8_addr[i] == c8)     m0 = q8_mask[i];
            if (q8_addr[i] == c8 + 3) m3 = q8_mask[i];
            if (q8_addr[i] == c8 + 8) m8 = q8_mask[i];
            nlk += q8_lk[i];
        end
        check("E_beats", q8_addr.size() - b, 197);
        check("E_mask_0_0", m0, 15);
        check("E_mask_0_3", m3, 14);
        check("E_mask_0_8", m8, 8);
        check("E_nlast", nlk, 1);
        if (q8_addr.size() > b) check("E_last_addr", q8_addr[q8_addr.size()-1], c8 + 2048);

        // Reset during the second keypoint, with start asserted alongside.
        kp_mem[0] = 16'd2570; kp_mem[1] = 16'd5000; kp_mem[2] = 16'd9000; kp_cnt = 9'd3;
        d0 = done2_n;
        pulse_start2();
        k = 0;
        while (!(rd2 == 9'd1 && bus2.addr_valid) && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        check("F_reached_kp1", int'(rd2 == 9'd1 && bus2.addr_valid), 1);
        rst = 1'b1; start2 = 1'b1;
        @(posedge clk); #1 rst = 1'b0; start2 = 1'b0;
        @(negedge clk);
        check_outputs_zero("F_RST");
        repeat (3) @(posedge clk);
        #1;
        check("F_start_ignored", busy2, 0);
        check("F_no_done", done2_n - d0, 0);
        b = q2_addr.size();
        pulse_start2();
        check("F_busy", busy2, 1);
        check("F_rd_restart", rd2, 0);
        wait_done2("F_done", 400);
        n = q2_addr.size() - b;
        nlk = 0; nla = 0;
        for (int i = 0; i < n; i++) begin
            nlk += q2_lk[b+i];
            nla += q2_la[b+i];
        end
        check("F_beats", n, 39);
        check("F_nlast_kp", nlk, 3);
        check("F_nlast_all", nla, 1);
        check("F_done_pulses", done2_n - d0, 1);
        if (n == 39) begin
            check("F_kp0_first", q2_addr[b], 2058);
            check("F_kp1_first", q2_addr[b+13], 4488);
            check("F_kp2_first", q2_addr[b+26], 8488);
            check("F_kp2_last", q2_addr[b+38], 9512);
            check("F_last_all_pos", q2_la[b+38], 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
